alu_seq: RTL and testbench

Parametrised successor to the single-operation adder/subtractor ALU.
- Executes an opcode-selected operation on two DATA_BITS operands.
- Uses a start/ready request handshake and a one-cycle out_valid strobe for results.
- Provides registered carry, zero, negative and overflow flags.
- Sits between the register file and the writeback stage of the processor datapath.
- Single-cycle ops complete in 1 cycle; the optional MUL op is iterative and takes multiple cycles.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq_mul.sv | 60 ++++++
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
// Opcode enum, FSM state enum and op_is_sub() helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_ADC = 3'd1,
    OP_SUB = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    MUL_DONE
  } alu_state_t;

  function automatic logic op_is_sub(
    input alu_op_t op
  );
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one bit per cycle.
// Ports: clk, reset, start, a, b -> done (last-iteration cycle), product.
`ifdef ALU_SEQ_MUL_EN
module alu_seq_mul #(
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = $clog2(DATA_BITS) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_BITS-1:0]   a,
  input  logic [DATA_BITS-1:0]   b,
  output logic                   done,
  output logic [2*DATA_BITS-1:0] product
);

  localparam int W = DATA_BITS;

  logic            busy;
  logic [CNT_BITS-1:0] cnt;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  // bit 0 of the partial product is always shifted out
  // before it is read, so it is never stored
  logic [2*W-1:1]  prod;
  logic [W:0]      sum;

  // product is the value after this cycle's iteration,
  // so the final result is usable in the done cycle
  always_comb begin
    sum = {1'b0, prod[2*W-1:W]}
        + (mplier[0] ? {1'b0, mcand} : '0);
    product = {sum, prod[W-1:1]};
    done = busy
        && (cnt == CNT_BITS'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      prod   <= '0;
    end else if (busy) begin
      prod   <= product[2*W-1:1];
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_BITS'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: opcode ALU with start/ready request and out_valid strobe.
// Macro ALU_SEQ_MUL_EN enables the iterative MUL (op=7) and its FSM.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  alu_op_t              op,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  input  logic                 cin,
  output logic                 ready,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] result,
  output logic                 cout,
  output logic                 zero,
  output logic                 neg,
  output logic                 ovf
);

  localparam int M = DATA_BITS - 1;

  logic [DATA_BITS-1:0] bb;
  logic [DATA_BITS-1:0] sc_res;
  logic [DATA_BITS:0]   sum;
  logic                 ci;
  logic                 sc_cout;
  logic                 sc_ovf;
  logic                 accept;

  assign accept = start && ready;

  // single-cycle datapath; op 7 here is the
  // illegal-op result when MUL is not built
  always_comb begin
    bb = op_is_sub(op) ? ~b : b;
    ci = (op == OP_ADC || op == OP_SBC)
       ? cin : (op == OP_SUB);
    sum = {1'b0, a} + {1'b0, bb}
        + {{DATA_BITS{1'b0}}, ci};
    sc_res  = '0;
    sc_cout = 1'b0;
    sc_ovf  = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        sc_res  = sum[M:0];
        sc_cout = sum[DATA_BITS];
        sc_ovf  = (a[M] == bb[M])
               && (sum[M] != a[M]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      default: sc_ovf = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_CNT_BITS =
    $clog2(DATA_BITS) + 1;

  alu_state_t             state;
  logic                   mul_start;
  logic                   mul_done;
  logic [2*DATA_BITS-1:0] mul_prod;

  assign mul_start = accept && (op == OP_MUL);

  alu_seq_mul #(
    .DATA_BITS (DATA_BITS),
    .CNT_BITS  (MUL_CNT_BITS)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (mul_start) begin
        state <= MUL_RUN;
        ready <= 1'b0;
      end else if (accept) begin
        state     <= IDLE;
        out_valid <= 1'b1;
        result    <= sc_res;
        cout      <= sc_cout;
        zero      <= ~|sc_res;
        neg       <= sc_res[M];
        ovf       <= sc_ovf;
      end else if (state == MUL_RUN
                   && mul_done) begin
        // outputs load on entry, so they are
        // visible during the MUL_DONE cycle
        state     <= MUL_DONE;
        ready     <= 1'b1;
        out_valid <= 1'b1;
        result    <= mul_prod[M:0];
        cout      <= 1'b0;
        zero      <= ~|mul_prod[M:0];
        neg       <= mul_prod[M];
        ovf       <= |mul_prod[2*DATA_BITS-1:DATA_BITS];
      end else if (state == MUL_DONE) begin
        state <= IDLE;
      end
    end
  end
`else
  assign ready = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        result <= sc_res;
        cout   <= sc_cout;
        zero   <= ~|sc_res;
        neg    <= sc_res[M];
        ovf    <= sc_ovf;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven bench for alu_seq (DATA_BITS=8).
// Covers single-cycle ops, back-to-back, MUL or illegal op 7.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  alu_op_t      op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         neg;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  alu_seq #(.DATA_BITS(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .ready     (ready),
    .out_valid (out_valid),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // {ready, out_valid, result, cout, zero, neg, ovf}
  typedef logic [W+5:0] obs_t;

  typedef struct {
    alu_op_t      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } vec_t;

  vec_t tbl [13];

  function automatic obs_t mk(
    input logic r, input logic vl,
    input logic [W-1:0] res,
    input logic c, input logic z,
    input logic n, input logic v
  );
    return {r, vl, res, c, z, n, v};
  endfunction

  function automatic obs_t cur();
    return {ready, out_valid, result,
            cout, zero, neg, ovf};
  endfunction

  task automatic chk(input string nm,
                     input obs_t act,
                     input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm,
                         input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_op_t o,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input logic c);
    op    = o;
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic mul_run(input logic [W-1:0] x,
                         input logic [W-1:0] y,
                         input logic [W-1:0] lo,
                         input logic v,
                         input logic pulse);
    int lat;
    int rlow;
    drive(OP_MUL, x, y, 1'b0);
    step();
    start = 1'b0;
    lat  = 1;
    rlow = 0;
    while (!out_valid && lat < 20) begin
      if (!ready) rlow++;
      if (pulse && lat == 4)
        drive(OP_ADD, 8'h01, 8'h01, 1'b0);
      step();
      start = 1'b0;
      lat++;
    end
    chk_int("mul_latency", lat, 9);
    chk_int("mul_ready_low", rlow, 8);
    chk("mul_result", cur(),
        mk(1'b1, 1'b1, lo, 1'b0,
           lo == '0, lo[W-1], v));
  endtask
`endif

  initial begin
    int nv;
    reset = 1'b1;
    start = 1'b0;
    op    = OP_ADD;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("reset", cur(),
        mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));

    tbl[0]  = '{OP_ADD, 8'hFF, 8'h01, 1'b0,
                8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{OP_SUB, 8'h80, 8'h01, 1'b0,
                8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{OP_SBC, 8'h05, 8'h05, 1'b0,
                8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{OP_ADC, 8'h7F, 8'h00, 1'b1,
                8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{OP_ADD, 8'h7F, 8'h01, 1'b0,
                8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{OP_SUB, 8'h05, 8'h05, 1'b0,
                8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{OP_SUB, 8'h03, 8'h05, 1'b0,
                8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{OP_SBC, 8'h10, 8'h05, 1'b1,
                8'h0B, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{OP_AND, 8'hF0, 8'h3C, 1'b0,
                8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{OP_OR,  8'h80, 8'h01, 1'b0,
                8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{OP_XOR, 8'hAA, 8'hAA, 1'b0,
                8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{OP_ADC, 8'hFF, 8'hFF, 1'b1,
                8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{OP_AND, 8'h0F, 8'hF0, 1'b1,
                8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].op, tbl[i].a,
            tbl[i].b, tbl[i].cin);
      step();
      start = 1'b0;
      chk($sformatf("vec%0d", i), cur(),
          mk(1'b1, 1'b1, tbl[i].res, tbl[i].c,
             tbl[i].z, tbl[i].n, tbl[i].v));
      step();
      chk($sformatf("vec%0d_hold", i), cur(),
          mk(1'b1, 1'b0, tbl[i].res, tbl[i].c,
             tbl[i].z, tbl[i].n, tbl[i].v));
    end

    drive(OP_XOR, 8'hF0, 8'hFF, 1'b0);
    step();
    chk("b2b_xor", cur(),
        mk(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(OP_AND, 8'h0F, 8'h03, 1'b0);
    step();
    start = 1'b0;
    chk("b2b_and", cur(),
        mk(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    chk("b2b_idle", cur(),
        mk(1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0));

`ifdef ALU_SEQ_MUL_EN
    mul_run(8'h10, 8'h11, 8'h10, 1'b1, 1'b1);
    drive(OP_ADD, 8'h02, 8'h03, 1'b0);
    step();
    start = 1'b0;
    chk("mul_done_accept", cur(),
        mk(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    chk("mul_after_idle", cur(),
        mk(1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0));
    mul_run(8'h00, 8'h55, 8'h00, 1'b0, 1'b0);
    mul_run(8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);
    mul_run(8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0);

    drive(OP_MUL, 8'h10, 8'h11, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_abort", cur(),
        mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid) nv++;
    end
    chk_int("rst_no_valid", nv, 0);
    drive(OP_ADD, 8'h02, 8'h03, 1'b0);
    step();
    start = 1'b0;
    chk("rst_then_add", cur(),
        mk(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0));
`else
    drive(OP_MUL, 8'h12, 8'h34, 1'b1);
    step();
    start = 1'b0;
    chk("op7_illegal", cur(),
        mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      if (!ready) nv++;
      step();
    end
    chk_int("op7_ready_low", nv, 0);
    chk("op7_hold", cur(),
        mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
